// File: rtl/ooo_resp_pkg.sv
// Shared widths and sizing helpers for the out-of-order read responder.
package ooo_resp_pkg;

  localparam int unsigned ID_W = 4;

  // Counter width that holds the largest latency LAT_BASE + 3*LAT_STEP.
  function automatic int unsigned cnt_width(input int unsigned lat_base,
                                            input int unsigned lat_step);
    return $clog2(lat_base + 3 * lat_step + 1);
  endfunction

endpackage

// File: rtl/first_one_picker.sv
// Lowest-set-bit selector: one-hot mask, binary index and any-set flag.
module first_one_picker #(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] onehot_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  assign onehot_c = req & (~req + WIDTH'(1));
  assign any_c    = |req;

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx_c = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) idx_c = IDX_W'(i);
    end
  end

endmodule

// File: rtl/ooo_read_responder.sv
// AR/R subordinate that answers reads after an ID-dependent latency;
// different IDs may overtake each other, same-ID responses stay in issue order.
module ooo_read_responder
  import ooo_resp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned LAT_BASE   = 2,
  parameter int unsigned LAT_STEP   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_W-1:0]       s_arid_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [ID_W-1:0]       s_rid_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i
);

  localparam int unsigned CNT_W = cnt_width(LAT_BASE, LAT_STEP);
  localparam int unsigned SEQ_W = DATA_WIDTH - ID_W;
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic                  valid;
    logic [ID_W-1:0]       id;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] data;
    logic [DEPTH-1:0]      dep;
  } slot_t;

  slot_t            slots [DEPTH];
  logic [SEQ_W-1:0] seq;

  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] same_id_vec;
  logic [DEPTH-1:0] elig_vec;
  logic [DEPTH-1:0] free_oh;
  logic [DEPTH-1:0] elig_oh;
  logic [DEPTH-1:0] pop_oh;
  logic [IDX_W-1:0] free_idx_unused;
  logic [IDX_W-1:0] elig_idx;
  logic             free_any;
  logic             elig_any;
  logic             alloc;
  logic             load;
  logic [CNT_W-1:0] new_cnt;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < DEPTH; i++) valid_vec[i] = slots[i].valid;
  end

  // A slot may leave only once aged out and every older same-ID slot has gone.
  always_comb begin
    same_id_vec = '0;
    elig_vec    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      same_id_vec[i] = slots[i].valid && (slots[i].id == s_arid_i);
      elig_vec[i]    = slots[i].valid && (slots[i].cnt == '0) &&
                       ((slots[i].dep & valid_vec) == '0);
    end
  end

  first_one_picker #(.WIDTH(DEPTH)) u_free_pick (
    .req      (~valid_vec),
    .onehot_c (free_oh),
    .idx_c    (free_idx_unused),
    .any_c    (free_any)
  );

  first_one_picker #(.WIDTH(DEPTH)) u_elig_pick (
    .req      (elig_vec),
    .onehot_c (elig_oh),
    .idx_c    (elig_idx),
    .any_c    (elig_any)
  );

  assign s_arready_o = ~rst & free_any;
  assign alloc       = s_arvalid_i & s_arready_o;
  assign load        = ~s_rvalid_o | s_rready_i;
  assign pop_oh      = load ? elig_oh : '0;
  assign new_cnt     = CNT_W'(LAT_BASE + LAT_STEP * 32'(s_arid_i[1:0]));

  // Slot table, aging, issue counter and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      seq        <= '0;
      s_rvalid_o <= 1'b0;
      s_rdata_o  <= '0;
      s_rid_o    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        // Dropping freed bits keeps a reused slot from blocking unrelated IDs.
        slots[i].dep <= slots[i].dep & ~pop_oh;
        if (pop_oh[i]) begin
          slots[i].valid <= 1'b0;
        end else if (slots[i].valid && (slots[i].cnt != '0)) begin
          slots[i].cnt <= slots[i].cnt - CNT_W'(1);
        end
        if (alloc && free_oh[i]) begin
          slots[i] <= '{valid: 1'b1, id: s_arid_i, cnt: new_cnt,
                        data: {seq, s_arid_i}, dep: same_id_vec & ~pop_oh};
        end
      end
      if (alloc) seq <= seq + SEQ_W'(1);
      if (load) begin
        s_rvalid_o <= elig_any;
        if (elig_any) begin
          s_rdata_o <= slots[elig_idx].data;
          s_rid_o   <= slots[elig_idx].id;
        end
      end
    end
  end

endmodule

// File: tb/tb_ooo_read_responder.sv
// Scoreboard bench: issued reads are queued with their expected data; a monitor
// matches each R beat against the oldest outstanding read of that ID.
module tb_ooo_read_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] arid = '0;
  logic       arvalid = 1'b0;
  logic       arready;
  logic [7:0] rdata;
  logic [3:0] rid;
  logic       rvalid;
  logic       rready = 1'b0;

  always #5 clk = ~clk;

  ooo_read_responder #(
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .LAT_BASE   (2),
    .LAT_STEP   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_arid_i    (arid),
    .s_arvalid_i (arvalid),
    .s_arready_o (arready),
    .s_rdata_o   (rdata),
    .s_rid_o     (rid),
    .s_rvalid_o  (rvalid),
    .s_rready_i  (rready)
  );

  typedef struct {
    logic [3:0] id;
    logic [7:0] data;
    int         issue;
  } exp_t;

  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  exp_t sb[$];
  int   seq = 0;
  int   beats = 0;
  logic [7:0] last_data = '0;
  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = '0;
  logic [3:0] hold_id = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: records accepted reads, checks beats and output hold stability.
  always @(negedge clk) begin : mon
    int   k;
    exp_t e;
    if (rst) begin
      sb.delete();
      seq       = 0;
      beats     = 0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", int'(rvalid), 1);
        chk("hold_data", int'(rdata), int'(hold_data));
        chk("hold_id", int'(rid), int'(hold_id));
      end
      if (rvalid && rready) begin
        k = -1;
        for (int j = 0; j < sb.size(); j++) begin
          if (sb[j].id == rid) begin
            k = j;
            break;
          end
        end
        if (k < 0) begin
          vectors++;
          errors++;
          $display("FAIL stale_beat: got rid %0d rdata 0x%0h, expected no beat (cycle %0d)",
                   rid, rdata, cyc);
        end else begin
          chk("rdata", int'(rdata), int'(sb[k].data));
          chk("min_latency", int'((cyc - sb[k].issue) >= (4 + 3 * int'(rid[1:0]))), 1);
          sb.delete(k);
        end
        beats++;
        last_data = rdata;
      end
      if (arvalid && arready) begin
        e.id    = arid;
        e.data  = 8'((seq << 4) | int'(arid));
        e.issue = cyc;
        sb.push_back(e);
        seq = (seq + 1) % 16;
      end
      hold_prev = rvalid && !rready;
      hold_data = rdata;
      hold_id   = rid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("arready_in_reset", int'(arready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rvalid", int'(rvalid), 0);
    chk("reset_rdata", int'(rdata), 0);
    chk("reset_rid", int'(rid), 0);
    chk("reset_arready", int'(arready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] id, output int t);
    int n;
    n       = 0;
    arid    = id;
    arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("ar_timeout", 1, 0);
    t = cyc;
    @(posedge clk);
    #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_beat(output int c, output logic [3:0] id, output logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!(rvalid && rready) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("r_timeout", 1, 0);
    c  = cyc;
    id = rid;
    d  = rdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t0, t1, c, c1, c2, acc;
    logic [3:0] i;
    logic [7:0] d;

    @(posedge clk);
    #1;

    // Single request, then a second one on the same ID.
    do_reset();
    rready = 1'b1;
    send(4'd0, t0);
    wait_beat(c, i, d);
    chk("single_latency", c - t0, 4);
    chk("single_rid", int'(i), 0);
    chk("single_rdata", int'(d), 8'h00);
    send(4'd0, t0);
    wait_beat(c, i, d);
    chk("second_rdata", int'(d), 8'h10);

    // Reorder: id 3 (long) overtaken by id 0 (short).
    do_reset();
    rready = 1'b1;
    send(4'd3, t0);
    send(4'd0, t1);
    wait_beat(c, i, d);
    chk("reorder_first_rid", int'(i), 0);
    chk("reorder_first_rdata", int'(d), 8'h10);
    chk("reorder_first_latency", c - t1, 4);
    wait_beat(c, i, d);
    chk("reorder_second_rid", int'(i), 3);
    chk("reorder_second_rdata", int'(d), 8'h03);
    chk("reorder_second_latency", c - t0, 13);

    // Same ID under backpressure drains in order on consecutive cycles.
    do_reset();
    rready = 1'b0;
    repeat (3) send(4'd5, t0);
    tick(20);
    rready = 1'b1;
    wait_beat(c, i, d);
    chk("sameid_rdata0", int'(d), 8'h05);
    chk("sameid_rid0", int'(i), 5);
    wait_beat(c1, i, d);
    chk("sameid_rdata1", int'(d), 8'h15);
    chk("sameid_gap1", c1 - c, 1);
    wait_beat(c2, i, d);
    chk("sameid_rdata2", int'(d), 8'h25);
    chk("sameid_gap2", c2 - c1, 1);

    // Full: 16 slots plus the output register, then one beat frees a slot.
    do_reset();
    rready  = 1'b0;
    arid    = 4'd0;
    arvalid = 1'b1;
    acc     = 0;
    repeat (40) begin
      @(negedge clk);
      if (arready) acc++;
    end
    chk("full_accepted", acc, 17);
    chk("full_arready", int'(arready), 0);
    @(posedge clk);
    #1;
    rready = 1'b1;
    @(negedge clk);
    chk("full_rvalid", int'(rvalid), 1);
    @(posedge clk);
    #1;
    rready  = 1'b0;
    arvalid = 1'b0;
    @(negedge clk);
    chk("full_arready_after_beat", int'(arready), 1);
    @(posedge clk);
    #1;
    rready = 1'b1;
    tick(80);
    chk("full_drained", sb.size(), 0);

    // Issue counter wrap over 17 requests.
    do_reset();
    rready = 1'b1;
    repeat (17) send(4'd0, t0);
    tick(30);
    chk("wrap_beats", beats, 17);
    chk("wrap_last_rdata", int'(last_data), 8'h00);

    // Reset with requests outstanding: nothing stale may come out.
    do_reset();
    rready = 1'b0;
    for (int k = 0; k < 4; k++) send(4'(k), t0);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_rvalid", int'(rvalid), 0);
    chk("midreset_arready", int'(arready), 1);
    @(posedge clk);
    #1;
    rready = 1'b1;
    tick(40);
    chk("midreset_no_stale", beats, 0);
    send(4'd1, t0);
    wait_beat(c, i, d);
    chk("midreset_new_rid", int'(i), 1);
    chk("midreset_new_rdata", int'(d), 8'h01);

    // Randomized traffic with random backpressure.
    do_reset();
    repeat (2000) begin
      arvalid = 1'($urandom_range(0, 1));
      arid    = 4'($urandom);
      rready  = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    arvalid = 1'b0;
    rready  = 1'b1;
    tick(150);
    chk("random_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
